// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver with shadowed data and leading-zero blanking
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1,
  parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [6:0]              sevenseg,
  output logic                    dp_n,
  output logic [IDX_W-1:0]        digit_idx
);
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_val;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_seg;
  logic                    r_dp_n;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_run;
  logic                    w_wrap;
  logic                    w_blank;
  logic [3:0]              w_nib;
  // w_lz[i]: every nibble from the top down to i is zero with no DP lit
  always_comb begin
    w_run = 1'b1;
    w_lz  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run   = w_run & (r_val[4*i +: 4] == 4'h0) & ~r_dp[i];
      w_lz[i] = w_run;
    end
  end
  assign w_wrap  = r_cnt == CNT_W'(REFRESH_DIV - 1);
  assign w_nib   = r_val[4*r_idx +: 4];
  assign w_blank = ~enable | (blank_lz & (r_idx != '0) & w_lz[r_idx]);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_val   <= '0;
      r_dp    <= '0;
      r_anode <= '1;
      r_seg   <= 7'h7F;
      r_dp_n  <= 1'b1;
    end else begin
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      r_idx   <= !w_wrap ? r_idx : (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_val   <= load ? value : r_val;
      r_dp    <= load ? dp_in : r_dp;
      r_anode <= enable ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_seg   <= w_blank ? 7'h7F : SEG[w_nib];
      r_dp_n  <= w_blank ? 1'b1 : ~r_dp[r_idx];
    end
  end
  assign anode_n   = r_anode;
  assign sevenseg  = r_seg;
  assign dp_n      = r_dp_n;
  assign digit_idx = r_idx;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for a 4-digit/div-4 instance plus a 1-digit/div-1 corner instance
module tb_seg7_scan_driver;
  localparam int N  = 4;
  localparam int RD = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, load = 1'b0, enable = 1'b1, blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  anode_n;
  logic [6:0]  sevenseg;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic        c_load = 1'b0;
  logic [3:0]  c_value = '0;
  logic [0:0]  c_anode;
  logic [6:0]  c_seg;
  logic        c_dp;
  logic [0:0]  c_idx;
  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .enable(enable),
    .blank_lz(blank_lz), .anode_n(anode_n), .sevenseg(sevenseg), .dp_n(dp_n), .digit_idx(digit_idx)
  );
  seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(1)) dut_c (
    .clk(clk), .rst(rst), .value(c_value), .dp_in(1'b0), .load(c_load), .enable(1'b1),
    .blank_lz(1'b0), .anode_n(c_anode), .sevenseg(c_seg), .dp_n(c_dp), .digit_idx(c_idx)
  );
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic [0:0] c_an;
    logic [6:0] c_seg;
    logic       c_dp;
  } exp_t;
  exp_t        q[$];
  int          n_vec = 0, n_err = 0;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  int          m_cnt, m_idx;
  logic [3:0]  cm_val;
  bit          dir_on = 1'b0;
  logic [6:0]  d_seg[4];
  logic        d_dp[4];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h27;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction
  function automatic bit lz(input int i);
    if (!blank_lz || i == 0) return 1'b0;
    for (int j = i; j < N; j++)
      if (m_val[4*j +: 4] != 4'h0 || m_dp[j]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic step();
    exp_t e, o;
    if (rst) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, idx: 2'd0, c_an: 1'b1, c_seg: 7'h7F, c_dp: 1'b1};
      m_val = '0; m_dp = '0; m_cnt = 0; m_idx = 0; cm_val = '0;
    end else begin
      e.an    = enable ? ~(4'b0001 << m_idx) : 4'hF;
      e.seg   = (!enable || lz(m_idx)) ? 7'h7F : seg_of(m_val[4*m_idx +: 4]);
      e.dp    = (!enable || lz(m_idx)) ? 1'b1 : ~m_dp[m_idx];
      e.c_an  = 1'b0;
      e.c_seg = seg_of(cm_val);
      e.c_dp  = 1'b1;
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % N;
      end else m_cnt++;
      e.idx = 2'(m_idx);
      if (load) begin m_val = value; m_dp = dp_in; end
      if (c_load) cm_val = c_value;
    end
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o = q.pop_front();
    chk("anode", 32'(anode_n), 32'(o.an));
    chk("seg", 32'(sevenseg), 32'(o.seg));
    chk("dp", 32'(dp_n), 32'(o.dp));
    chk("idx", 32'(digit_idx), 32'(o.idx));
    chk("c_anode", 32'(c_anode), 32'(o.c_an));
    chk("c_seg", 32'(c_seg), 32'(o.c_seg));
    chk("c_dp", 32'(c_dp), 32'(o.c_dp));
    chk("c_idx", 32'(c_idx), 32'd0);
    if (dir_on)
      for (int d = 0; d < N; d++)
        if (anode_n == ~(4'b0001 << d)) begin
          chk("dir_seg", 32'(sevenseg), 32'(d_seg[d]));
          chk("dir_dp", 32'(dp_n), 32'(d_dp[d]));
        end
  endtask
  task automatic load_scan(input logic [15:0] v, input logic [3:0] d, input logic b);
    value = v; dp_in = d; blank_lz = b; load = 1'b1;
    step();
    load = 1'b0; value = $urandom; dp_in = 4'($urandom);
    step();
    dir_on = 1'b1;
    repeat (16) step();
    dir_on = 1'b0;
  endtask
  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("post_rst_anode", 32'(anode_n), 32'h0000000E);
    repeat (4) step();
    chk("post_rst_idx1", 32'(digit_idx), 32'd1);
    d_seg = '{7'h0E, 7'h08, 7'h24, 7'h79}; d_dp = '{1'b1, 1'b1, 1'b0, 1'b1};
    load_scan(16'h12AF, 4'b0100, 1'b0);
    d_seg = '{7'h40, 7'h30, 7'h7F, 7'h7F}; d_dp = '{1'b1, 1'b1, 1'b1, 1'b1};
    load_scan(16'h0030, 4'b0000, 1'b1);
    d_seg = '{7'h40, 7'h30, 7'h40, 7'h40};
    load_scan(16'h0030, 4'b0000, 1'b0);
    d_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    load_scan(16'h0000, 4'b0000, 1'b1);
    d_seg = '{7'h12, 7'h40, 7'h40, 7'h7F}; d_dp = '{1'b1, 1'b1, 1'b0, 1'b1};
    load_scan(16'h0005, 4'b0100, 1'b1);
    enable = 1'b0;
    repeat (5) begin
      step();
      chk("en_off", 32'(anode_n), 32'h0000000F);
    end
    enable = 1'b1;
    step();
    for (int i = 0; i < 20 && m_idx != 2; i++) step();
    step();
    value = 16'hFFFF; dp_in = 4'hF; load = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; load = 1'b0;
    chk("midrst_seg", 32'(sevenseg), 32'h7F);
    repeat (3) step();
    c_value = 4'hB; c_load = 1'b1;
    step();
    c_load = 1'b0; c_value = 4'h0;
    step();
    chk("c_load_b", 32'(c_seg), 32'h03);
    repeat (60) begin
      value    = $urandom;
      value[15:8] = ($urandom_range(0, 1) != 0) ? 8'h00 : value[15:8];
      dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load     = $urandom_range(0, 3) == 0;
      enable   = $urandom_range(0, 7) != 0;
      blank_lz = $urandom_range(0, 1) != 0;
      c_value  = 4'($urandom);
      c_load   = $urandom_range(0, 1) != 0;
      rst      = $urandom_range(0, 29) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
